// File: rtl/vga_pattern_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
package vga_pattern_pkg;

  typedef enum logic [2:0] {
    MODE_BARS  = 3'd0,
    MODE_CHECK = 3'd1,
    MODE_GRID  = 3'd2,
    MODE_GRAD  = 3'd3,
    MODE_BOX   = 3'd4
  } mode_t;

  // {R,G,B} enables per bar, entry 0 is the leftmost (white) bar.
  localparam logic [7:0][2:0] BAR_RGB_EN = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/vga_box_tracker.sv
// Bouncing-box position/direction state; steps once per frame end while enabled.
module vga_box_tracker
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 10,
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fe,
  input  logic             enable,
  output logic [COL_W-1:0] box_x,
  output logic [ROW_W-1:0] box_y
);

  localparam logic [COL_W:0] X_MAX  = (COL_W+1)'(H_ACTIVE - BOX_SIZE);
  localparam logic [COL_W:0] X_STEP = (COL_W+1)'(BOX_STEP);
  localparam logic [ROW_W:0] Y_MAX  = (ROW_W+1)'(V_ACTIVE - BOX_SIZE);
  localparam logic [ROW_W:0] Y_STEP = (ROW_W+1)'(BOX_STEP);

  logic [COL_W-1:0] box_x_q, box_x_d;
  logic [ROW_W-1:0] box_y_q, box_y_d;
  logic             dir_x_neg_q, dir_x_neg_d;
  logic             dir_y_neg_q, dir_y_neg_d;
  logic [COL_W:0]   x_ext_s;
  logic [ROW_W:0]   y_ext_s;

  assign x_ext_s = {1'b0, box_x_q};
  assign y_ext_s = {1'b0, box_y_q};

  // Next position: clamp to the wall and reverse when the next step would reach it.
  always_comb begin
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dir_x_neg_d = dir_x_neg_q;
    dir_y_neg_d = dir_y_neg_q;
    if (fe && enable) begin
      if (!dir_x_neg_q) begin
        if (x_ext_s + X_STEP >= X_MAX) begin
          box_x_d     = X_MAX[COL_W-1:0];
          dir_x_neg_d = 1'b1;
        end else begin
          box_x_d = box_x_q + X_STEP[COL_W-1:0];
        end
      end else begin
        if (x_ext_s <= X_STEP) begin
          box_x_d     = {COL_W{1'b0}};
          dir_x_neg_d = 1'b0;
        end else begin
          box_x_d = box_x_q - X_STEP[COL_W-1:0];
        end
      end
      if (!dir_y_neg_q) begin
        if (y_ext_s + Y_STEP >= Y_MAX) begin
          box_y_d     = Y_MAX[ROW_W-1:0];
          dir_y_neg_d = 1'b1;
        end else begin
          box_y_d = box_y_q + Y_STEP[ROW_W-1:0];
        end
      end else begin
        if (y_ext_s <= Y_STEP) begin
          box_y_d     = {ROW_W{1'b0}};
          dir_y_neg_d = 1'b0;
        end else begin
          box_y_d = box_y_q - Y_STEP[ROW_W-1:0];
        end
      end
    end else begin
      box_x_d = box_x_q;
      box_y_d = box_y_q;
    end
  end

  // Box state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      box_x_q     <= {COL_W{1'b0}};
      box_y_q     <= {ROW_W{1'b0}};
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
    end else begin
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_neg_q <= dir_x_neg_d;
      dir_y_neg_q <= dir_y_neg_d;
    end
  end

  assign box_x = box_x_q;
  assign box_y = box_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator: per-mode colour mux into a registered
// output stage; mode and box state change only at the frame-end pixel.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int COL_W     = 10,
  parameter int ROW_W     = 10,
  parameter int COLOR_W   = 8,
  parameter int CELL_LOG2 = 5,
  parameter int BOX_SIZE  = 32,
  parameter int BOX_STEP  = 4,
  parameter int BG_LEVEL  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         mode_sel,
  input  logic [ROW_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  input  logic               blank,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               blank_out,
  output logic [2:0]         mode_active,
  output logic [15:0]        frame_count
);

  localparam logic [COLOR_W-1:0] FULL     = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] BG       = COLOR_W'(BG_LEVEL);
  localparam logic [COLOR_W-1:0] ZERO     = {COLOR_W{1'b0}};
  localparam logic [COL_W-1:0]   BAR_W    = COL_W'(H_ACTIVE / 8);
  localparam logic [COL_W-1:0]   LAST_COL = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(V_ACTIVE - 1);
  localparam logic [ROW_W-1:0]   HALF_ROW = ROW_W'(V_ACTIVE / 2);
  localparam logic [COL_W:0]     BOX_X_SZ = (COL_W+1)'(BOX_SIZE);
  localparam logic [ROW_W:0]     BOX_Y_SZ = (ROW_W+1)'(BOX_SIZE);

  logic [COLOR_W-1:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic               blank_out_q, blank_out_d;
  logic [2:0]         mode_active_q, mode_active_d;
  logic [15:0]        frame_count_q, frame_count_d;

  logic               fe_s;
  logic [COL_W-1:0]   box_x_s;
  logic [ROW_W-1:0]   box_y_s;
  logic [COL_W-1:0]   bar_div_s;
  logic [2:0]         bar_idx_s;
  logic [2:0]         bar_en_s;
  logic [COLOR_W-1:0] off_lvl_s;
  logic [COLOR_W-1:0] mono_s;
  logic               in_box_s;

  assign fe_s      = !blank && (row == LAST_ROW) && (col == LAST_COL);
  assign bar_div_s = col / BAR_W;
  assign bar_idx_s = (bar_div_s > COL_W'(7)) ? 3'd7 : bar_div_s[2:0];
  assign bar_en_s  = BAR_RGB_EN[bar_idx_s];
  assign off_lvl_s = (row < HALF_ROW) ? BG : ZERO;
  assign in_box_s  = ({1'b0, col} >= {1'b0, box_x_s}) &&
                     ({1'b0, col} <  {1'b0, box_x_s} + BOX_X_SZ) &&
                     ({1'b0, row} >= {1'b0, box_y_s}) &&
                     ({1'b0, row} <  {1'b0, box_y_s} + BOX_Y_SZ);

  vga_box_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box (
    .clk     (clk),
    .reset_n (reset_n),
    .fe      (fe_s),
    .enable  (mode_active_q == MODE_BOX),
    .box_x   (box_x_s),
    .box_y   (box_y_s)
  );

  // Per-mode pixel colour for the current input pixel.
  always_comb begin
    mono_s  = ZERO;
    vga_r_d = BG;
    vga_g_d = BG;
    vga_b_d = BG;
    if (blank) begin
      vga_r_d = ZERO;
      vga_g_d = ZERO;
      vga_b_d = ZERO;
    end else begin
      case (mode_active_q)
        MODE_BARS: begin
          vga_r_d = bar_en_s[2] ? FULL : off_lvl_s;
          vga_g_d = bar_en_s[1] ? FULL : off_lvl_s;
          vga_b_d = bar_en_s[0] ? FULL : off_lvl_s;
        end
        MODE_CHECK: begin
          mono_s  = (row[CELL_LOG2] ^ col[CELL_LOG2]) ? FULL : ZERO;
          vga_r_d = mono_s;
          vga_g_d = mono_s;
          vga_b_d = mono_s;
        end
        MODE_GRID: begin
          mono_s  = ((row[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}}) ||
                     (col[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}}) ||
                     (row == LAST_ROW) || (col == LAST_COL)) ? FULL : ZERO;
          vga_r_d = mono_s;
          vga_g_d = mono_s;
          vga_b_d = mono_s;
        end
        MODE_GRAD: begin
          vga_r_d = col[COL_W-1 -: COLOR_W];
          vga_g_d = row[ROW_W-1 -: COLOR_W];
          vga_b_d = FULL - col[COL_W-1 -: COLOR_W];
        end
        MODE_BOX: begin
          mono_s  = in_box_s ? FULL : BG;
          vga_r_d = mono_s;
          vga_g_d = mono_s;
          vga_b_d = mono_s;
        end
        default: begin
          vga_r_d = BG;
          vga_g_d = BG;
          vga_b_d = BG;
        end
      endcase
    end
  end

  // Frame-boundary state: the mode latch and frame counter advance only on fe.
  always_comb begin
    blank_out_d = blank;
    if (fe_s) begin
      mode_active_d = mode_sel;
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      mode_active_d = mode_active_q;
      frame_count_d = frame_count_q;
    end
  end

  // Output and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vga_r_q       <= ZERO;
      vga_g_q       <= ZERO;
      vga_b_q       <= ZERO;
      blank_out_q   <= 1'b1;
      mode_active_q <= 3'd0;
      frame_count_q <= 16'd0;
    end else begin
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      blank_out_q   <= blank_out_d;
      mode_active_q <= mode_active_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign blank_out   = blank_out_q;
  assign mode_active = mode_active_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: table vectors, corner sequences and
// randomized pixels compared against an arithmetic reference model.
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] mode_sel;
  logic [9:0] row;
  logic [9:0] col;
  logic       blank;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       blank_out;
  logic [2:0] mode_active;
  logic [15:0] frame_count;

  always #10 clk = ~clk;

  vga_pattern_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode_sel    (mode_sel),
    .row         (row),
    .col         (col),
    .blank       (blank),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .blank_out   (blank_out),
    .mode_active (mode_active),
    .frame_count (frame_count)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_mode, m_fc, m_bx, m_by, m_dx, m_dy;

  typedef struct {
    int          row;
    int          col;
    bit          blank;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_pix(input int mode, input int r, input int c,
                                            input bit bl, input int bx, input int by);
    int i, rr, gg, bb, off, v;
    if (bl) return 24'h0;
    rr = 32; gg = 32; bb = 32;
    case (mode)
      0: begin
        i   = c / 80;
        off = (r < 240) ? 32 : 0;
        rr  = ((i % 4) < 2) ? 255 : off;
        gg  = (i < 4) ? 255 : off;
        bb  = ((i % 2) == 0) ? 255 : off;
      end
      1: begin
        v = ((((r / 32) + (c / 32)) % 2) == 1) ? 255 : 0;
        rr = v; gg = v; bb = v;
      end
      2: begin
        v = ((r % 32) == 0 || (c % 32) == 0 || r == 479 || c == 639) ? 255 : 0;
        rr = v; gg = v; bb = v;
      end
      3: begin
        rr = (c / 4) % 256;
        gg = (r / 4) % 256;
        bb = 255 - rr;
      end
      4: begin
        v = (c >= bx && c < bx + 32 && r >= by && r < by + 32) ? 255 : 32;
        rr = v; gg = v; bb = v;
      end
      default: begin
        rr = 32; gg = 32; bb = 32;
      end
    endcase
    return {8'(rr), 8'(gg), 8'(bb)};
  endfunction

  function automatic void axis_move(inout int pos, inout int dir, input int lim);
    if (dir > 0) begin
      if (pos + 4 >= lim - 32) begin pos = lim - 32; dir = -1; end
      else pos = pos + 4;
    end else begin
      if (pos <= 4) begin pos = 0; dir = 1; end
      else pos = pos - 4;
    end
  endfunction

  // One clock: drive inputs, advance the model, then check all outputs after the edge.
  task automatic cycle(input int r, input int c, input bit bl, input int ms, input bit rst);
    logic [23:0] exp;
    bit fe;
    row      = 10'(r);
    col      = 10'(c);
    blank    = bl;
    mode_sel = 3'(ms);
    reset_n  = ~rst;
    exp = rst ? 24'h0 : model_pix(m_mode, r, c, bl, m_bx, m_by);
    fe  = !bl && r == 479 && c == 639;
    if (rst) begin
      m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    end else if (fe) begin
      if (m_mode == 4) begin
        axis_move(m_bx, m_dx, 640);
        axis_move(m_by, m_dy, 480);
      end
      m_mode = ms;
      m_fc   = (m_fc + 1) % 65536;
    end
    @(posedge clk);
    #1;
    chk("pix", {vga_r, vga_g, vga_b}, exp);
    chk("blank_out", blank_out, rst ? 1 : bl);
    chk("mode_active", mode_active, m_mode);
    chk("frame_count", frame_count, m_fc);
  endtask

  task automatic fe_cycle(input int ms);
    cycle(479, 639, 1'b0, ms, 1'b0);
  endtask

  task automatic pix_is(input string name, input logic [23:0] exp);
    chk(name, {vga_r, vga_g, vga_b}, exp);
  endtask

  initial begin
    tbl[0] = '{0,   0,   1'b0, 24'hFFFFFF};
    tbl[1] = '{0,   79,  1'b0, 24'hFFFFFF};
    tbl[2] = '{0,   80,  1'b0, 24'hFFFF20};
    tbl[3] = '{0,   400, 1'b0, 24'hFF2020};
    tbl[4] = '{0,   639, 1'b0, 24'h202020};
    tbl[5] = '{300, 400, 1'b0, 24'hFF0000};
    tbl[6] = '{10,  10,  1'b1, 24'h000000};
    tbl[7] = '{10,  11,  1'b0, 24'hFFFFFF};

    m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;

    cycle(0, 0, 1'b0, 0, 1'b1);
    cycle(0, 0, 1'b0, 0, 1'b1);
    pix_is("rst_rgb", 24'h0);
    chk("rst_blank", blank_out, 1);
    chk("rst_mode", mode_active, 0);
    chk("rst_fc", frame_count, 0);

    // colour bars and blanking from the table, one pixel per clock
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].row, tbl[i].col, tbl[i].blank, 0, 1'b0);
      pix_is("bar_tbl", tbl[i].exp);
      chk("bar_tbl_blank", blank_out, tbl[i].blank);
    end

    // deferred mode change
    cycle(100, 5, 1'b0, 1, 1'b0);
    chk("defer_mode", mode_active, 0);
    cycle(300, 200, 1'b0, 1, 1'b0);
    pix_is("defer_bars", 24'h00FFFF);
    fe_cycle(1);
    pix_is("fe_old_mode", 24'h000000);
    chk("fe_mode", mode_active, 1);
    chk("fe_count", frame_count, 1);
    cycle(0, 0, 1'b0, 1, 1'b0);
    pix_is("chk_00", 24'h000000);
    cycle(0, 32, 1'b0, 1, 1'b0);
    pix_is("chk_0_32", 24'hFFFFFF);
    cycle(32, 32, 1'b0, 1, 1'b0);
    pix_is("chk_32_32", 24'h000000);

    // box bounce at the right wall
    fe_cycle(4);
    cycle(0, 0, 1'b0, 4, 1'b0);
    pix_is("box_origin", 24'hFFFFFF);
    cycle(0, 32, 1'b0, 4, 1'b0);
    pix_is("box_right_out", 24'h202020);
    for (int i = 0; i < 151; i++) fe_cycle(4);
    fe_cycle(4);
    cycle(m_by, 608, 1'b0, 4, 1'b0);
    pix_is("box_wall_in", 24'hFFFFFF);
    cycle(m_by, 607, 1'b0, 4, 1'b0);
    pix_is("box_wall_out", 24'h202020);
    fe_cycle(4);
    cycle(m_by, 604, 1'b0, 4, 1'b0);
    pix_is("box_back_in", 24'hFFFFFF);
    cycle(m_by, 603, 1'b0, 4, 1'b0);
    pix_is("box_back_left", 24'h202020);
    cycle(m_by, 636, 1'b0, 4, 1'b0);
    pix_is("box_back_right", 24'h202020);

    // mid-frame reset while drawing the box
    cycle(200, 100, 1'b0, 4, 1'b1);
    pix_is("mrst_rgb", 24'h0);
    chk("mrst_blank", blank_out, 1);
    chk("mrst_mode", mode_active, 0);
    chk("mrst_fc", frame_count, 0);
    cycle(201, 0, 1'b0, 4, 1'b0);
    pix_is("mrst_resume", 24'hFFFFFF);
    fe_cycle(4);
    cycle(0, 0, 1'b0, 4, 1'b0);
    pix_is("mrst_box00", 24'hFFFFFF);
    cycle(31, 31, 1'b0, 4, 1'b0);
    pix_is("mrst_box31", 24'hFFFFFF);
    cycle(32, 32, 1'b0, 4, 1'b0);
    pix_is("mrst_box32", 24'h202020);

    // randomized pixels with sprinkled frame ends and rare resets
    for (int i = 0; i < 4000; i++) begin
      int r, c, ms;
      bit bl, rst;
      ms  = int'($urandom_range(0, 7));
      rst = ($urandom_range(0, 511) == 0);
      if ($urandom_range(0, 15) == 0) begin
        r = 479; c = 639; bl = 1'b0;
      end else begin
        r  = int'($urandom_range(0, 479));
        c  = int'($urandom_range(0, 639));
        bl = ($urandom_range(0, 7) == 0);
      end
      cycle(r, c, bl, ms, rst);
    end

    // frame counter wrap
    cycle(0, 0, 1'b0, 5, 1'b1);
    for (int i = 0; i < 65536; i++) fe_cycle(5);
    chk("fc_wrap", frame_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
